// File: rtl/br_resolve_agex.sv
// AGEX branch resolution: evaluates control flow, emits the FE feedback
// packet, squashes the wrong-path window and keeps saturating statistics.
module br_resolve_agex #(
  parameter int unsigned DBITS         = 32,
  parameter int unsigned INSTSIZE      = 4,
  parameter int unsigned SQUASH_CYCLES = 2,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_stall,
  input  logic [DBITS-1:0] in_pc,
  input  logic [DBITS-1:0] in_pred_npc,
  input  logic             in_is_br,
  input  logic             in_is_jal,
  input  logic             in_is_jalr,
  input  logic [2:0]       in_funct3,
  input  logic [DBITS-1:0] in_rs1,
  input  logic [DBITS-1:0] in_rs2,
  input  logic [DBITS-1:0] in_imm,
  output logic             fe_mispred,
  output logic [DBITS-1:0] fe_target,
  output logic [DBITS-1:0] fe_pc,
  output logic             fe_is_br,
  output logic             fe_is_jmp,
  output logic             fe_br_cond,
  output logic             squash_out,
  output logic [CNT_W-1:0] cnt_ctrl,
  output logic [CNT_W-1:0] cnt_mispred
);

  typedef enum logic {RUN, SQUASH} state_t;

  localparam logic [DBITS-1:0] JALR_MASK = {{(DBITS-1){1'b1}}, 1'b0};

  state_t           state_q, state_d;
  logic [2:0]       sq_cnt_q, sq_cnt_d;
  logic             mis_q, mis_d;
  logic [DBITS-1:0] tgt_q, tgt_d;
  logic [DBITS-1:0] pc_q, pc_d;
  logic             isbr_q, isbr_d;
  logic             isjmp_q, isjmp_d;
  logic             cond_q, cond_d;
  logic [CNT_W-1:0] cctl_q, cctl_d;
  logic [CNT_W-1:0] cmis_q, cmis_d;

  logic             squashing;
  logic             accept;
  logic             is_jmp;
  logic             is_ctrl;
  logic             cond;
  logic             taken;
  logic [DBITS-1:0] target;
  logic [DBITS-1:0] seq_npc;
  logic [DBITS-1:0] actual_npc;
  logic             res;
  logic             mispred;

  assign squashing = (state_q == SQUASH);
  assign accept    = in_valid & ~in_stall & ~squashing;
  assign is_jmp    = in_is_jal | in_is_jalr;
  assign is_ctrl   = is_jmp | in_is_br;

  always_comb begin
    cond = 1'b0;
    case (in_funct3)
      3'b000:  cond = (in_rs1 == in_rs2);
      3'b001:  cond = (in_rs1 != in_rs2);
      3'b100:  cond = ($signed(in_rs1) < $signed(in_rs2));
      3'b101:  cond = ($signed(in_rs1) >= $signed(in_rs2));
      3'b110:  cond = (in_rs1 < in_rs2);
      3'b111:  cond = (in_rs1 >= in_rs2);
      default: cond = 1'b0;
    endcase
  end

  // Jumps always take; a stray is_br alongside a jump is ignored.
  assign taken      = is_jmp | (in_is_br & cond);
  assign seq_npc    = in_pc + DBITS'(INSTSIZE);
  assign target     = in_is_jalr ? ((in_rs1 + in_imm) & JALR_MASK)
                                 : (in_pc + in_imm);
  assign actual_npc = taken ? target : seq_npc;
  assign res        = accept & is_ctrl;
  assign mispred    = res & (actual_npc != in_pred_npc);

  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mispred) begin
          state_d  = SQUASH;
          sq_cnt_d = 3'(SQUASH_CYCLES);
        end
      end
      SQUASH: begin
        if (!in_stall) begin
          sq_cnt_d = sq_cnt_q - 3'd1;
          if (sq_cnt_q == 3'd1) state_d = RUN;
        end
      end
    endcase
  end

  always_comb begin
    mis_d   = 1'b0;
    tgt_d   = '0;
    pc_d    = '0;
    isbr_d  = 1'b0;
    isjmp_d = 1'b0;
    cond_d  = 1'b0;
    if (res) begin
      mis_d   = mispred;
      tgt_d   = actual_npc;
      pc_d    = in_pc;
      isbr_d  = in_is_br & ~is_jmp;
      isjmp_d = is_jmp;
      cond_d  = taken;
    end
  end

  always_comb begin
    cctl_d = cctl_q;
    cmis_d = cmis_q;
    if (res && (cctl_q != '1)) cctl_d = cctl_q + 1'b1;
    if (mispred && (cmis_q != '1)) cmis_d = cmis_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= RUN;
      sq_cnt_q <= '0;
      mis_q    <= 1'b0;
      tgt_q    <= '0;
      pc_q     <= '0;
      isbr_q   <= 1'b0;
      isjmp_q  <= 1'b0;
      cond_q   <= 1'b0;
      cctl_q   <= '0;
      cmis_q   <= '0;
    end else begin
      state_q  <= state_d;
      sq_cnt_q <= sq_cnt_d;
      mis_q    <= mis_d;
      tgt_q    <= tgt_d;
      pc_q     <= pc_d;
      isbr_q   <= isbr_d;
      isjmp_q  <= isjmp_d;
      cond_q   <= cond_d;
      cctl_q   <= cctl_d;
      cmis_q   <= cmis_d;
    end
  end

  assign squash_out  = squashing & in_valid;
  assign fe_mispred  = mis_q;
  assign fe_target   = tgt_q;
  assign fe_pc       = pc_q;
  assign fe_is_br    = isbr_q;
  assign fe_is_jmp   = isjmp_q;
  assign fe_br_cond  = cond_q;
  assign cnt_ctrl    = cctl_q;
  assign cnt_mispred = cmis_q;

endmodule

// File: tb/tb_br_resolve_agex.sv
// Scoreboard bench for br_resolve_agex: directed vectors push expected
// FE packets; a negedge monitor pops and compares each resolution pulse.
module tb_br_resolve_agex;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        br;
    logic        jmp;
    logic        cond;
    logic        mis;
    int          due;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v, st, br, jal, jalr;
  logic [2:0]  f3;
  logic [31:0] pc, pnpc, rs1, rs2, imm;

  logic        a_mis, a_br, a_jmp, a_cond, a_sq;
  logic [31:0] a_tgt, a_pc, a_cc, a_cm;
  logic        b_mis, b_br, b_jmp, b_cond, b_sq;
  logic [31:0] b_tgt, b_pc;
  logic [3:0]  b_cc, b_cm;

  pkt_t q[$];
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  br_resolve_agex #(.DBITS(32), .INSTSIZE(4), .SQUASH_CYCLES(2), .CNT_W(32)) u_dut (
    .clk(clk), .reset(rst_n), .in_valid(v), .in_stall(st),
    .in_pc(pc), .in_pred_npc(pnpc), .in_is_br(br), .in_is_jal(jal),
    .in_is_jalr(jalr), .in_funct3(f3), .in_rs1(rs1), .in_rs2(rs2),
    .in_imm(imm), .fe_mispred(a_mis), .fe_target(a_tgt), .fe_pc(a_pc),
    .fe_is_br(a_br), .fe_is_jmp(a_jmp), .fe_br_cond(a_cond),
    .squash_out(a_sq), .cnt_ctrl(a_cc), .cnt_mispred(a_cm)
  );

  br_resolve_agex #(.DBITS(32), .INSTSIZE(4), .SQUASH_CYCLES(2), .CNT_W(4)) u_sat (
    .clk(clk), .reset(rst_n), .in_valid(v), .in_stall(st),
    .in_pc(pc), .in_pred_npc(pnpc), .in_is_br(br), .in_is_jal(jal),
    .in_is_jalr(jalr), .in_funct3(f3), .in_rs1(rs1), .in_rs2(rs2),
    .in_imm(imm), .fe_mispred(b_mis), .fe_target(b_tgt), .fe_pc(b_pc),
    .fe_is_br(b_br), .fe_is_jmp(b_jmp), .fe_br_cond(b_cond),
    .squash_out(b_sq), .cnt_ctrl(b_cc), .cnt_mispred(b_cm)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (a_br | a_jmp) begin
        if (q.size() == 0) begin
          chk("extra_pulse", {a_pc}, 32'hFFFF_FFFF);
        end else begin
          pkt_t e;
          e = q.pop_front();
          chk("pkt_due", cyc, e.due);
          chk("fe_pc", a_pc, e.pc);
          chk("fe_target", a_tgt, e.tgt);
          chk("fe_is_br", {31'd0, a_br}, {31'd0, e.br});
          chk("fe_is_jmp", {31'd0, a_jmp}, {31'd0, e.jmp});
          chk("fe_br_cond", {31'd0, a_cond}, {31'd0, e.cond});
          chk("fe_mispred", {31'd0, a_mis}, {31'd0, e.mis});
        end
      end else begin
        if (a_mis | a_cond)
          chk("stray_flags", {30'd0, a_mis, a_cond}, 32'd0);
        if (q.size() != 0 && q[0].due <= cyc) begin
          chk("missing_pulse", 32'd0, q[0].pc);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic expect_pkt(input logic [31:0] epc, etgt,
                            input logic ebr, ejmp, econd, emis);
    pkt_t e;
    e.pc = epc; e.tgt = etgt; e.br = ebr; e.jmp = ejmp;
    e.cond = econd; e.mis = emis; e.due = cyc + 1;
    q.push_back(e);
  endtask

  task automatic step(input logic iv, ist, ibr, ijal, ijalr,
                      input logic [2:0] if3,
                      input logic [31:0] ipc, ipn, irs1, irs2, iimm,
                      input logic exp_sq);
    v = iv; st = ist; br = ibr; jal = ijal; jalr = ijalr; f3 = if3;
    pc = ipc; pnpc = ipn; rs1 = irs1; rs2 = irs2; imm = iimm;
    @(negedge clk);
    chk("squash_out", {31'd0, a_sq}, {31'd0, exp_sq});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic exp_sq);
    step(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, exp_sq);
  endtask

  task automatic nop(input logic ist, input logic exp_sq);
    step(1, ist, 0, 0, 0, 3'd0, 32'h0000_0F00, 32'h0000_0F04, 0, 0, 0, exp_sq);
  endtask

  task automatic chk_cnt(input logic [31:0] c, m);
    chk("cnt_ctrl", a_cc, c);
    chk("cnt_mispred", a_cm, m);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_fe"}, {26'd0, a_mis, a_br, a_jmp, a_cond, b_mis, b_sq}, 32'd0);
    chk({nm, "_tgt"}, a_tgt | a_pc, 32'd0);
    chk({nm, "_cnt"}, a_cc | a_cm, 32'd0);
    chk({nm, "_satcnt"}, {24'd0, b_cc, b_cm}, 32'd0);
  endtask

  initial begin
    v = 0; st = 0; br = 0; jal = 0; jalr = 0; f3 = 0;
    pc = 0; pnpc = 0; rs1 = 0; rs2 = 0; imm = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // BEQ taken, predicted correctly
    expect_pkt(32'h100, 32'h120, 1, 0, 1, 0);
    step(1, 0, 1, 0, 0, 3'b000, 32'h100, 32'h120, 5, 5, 32'h20, 0);
    chk_cnt(1, 0);

    // BLT signed taken, predicted fall-through -> redirect + 2-slot squash
    expect_pkt(32'h200, 32'h240, 1, 0, 1, 1);
    step(1, 0, 1, 0, 0, 3'b100, 32'h200, 32'h204, 32'hFFFF_FFFF, 1, 32'h40, 0);
    chk_cnt(2, 1);
    nop(0, 1);
    nop(0, 1);

    // BLTU same operands: not taken, correct
    expect_pkt(32'h200, 32'h204, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 3'b110, 32'h200, 32'h204, 32'hFFFF_FFFF, 1, 32'h40, 0);
    chk_cnt(3, 1);

    // JALR with odd target: bit0 cleared
    expect_pkt(32'h300, 32'h1012, 0, 1, 1, 1);
    step(1, 0, 0, 0, 1, 3'b000, 32'h300, 32'h0, 32'h1003, 0, 32'h10, 0);
    chk_cnt(4, 2);
    idle(0);
    idle(0);

    // BNE held 3 cycles by stall, resolved once on release
    repeat (3) step(1, 1, 1, 0, 0, 3'b001, 32'h400, 32'h404, 1, 2, 32'h8, 0);
    chk_cnt(4, 2);
    expect_pkt(32'h400, 32'h408, 1, 0, 1, 1);
    step(1, 0, 1, 0, 0, 3'b001, 32'h400, 32'h404, 1, 2, 32'h8, 0);
    chk_cnt(5, 3);

    // Stalls during squash extend the window
    nop(1, 1);
    nop(1, 1);
    nop(0, 1);
    nop(0, 1);

    // JAL with stray is_br: jump wins
    expect_pkt(32'h500, 32'h600, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0, 3'b000, 32'h500, 32'h600, 0, 0, 32'h100, 0);
    // funct3 010 evaluates not-taken even with equal operands
    expect_pkt(32'h600, 32'h604, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 3'b010, 32'h600, 32'h604, 7, 7, 32'h40, 0);
    // BGE signed: -1 >= 1 false
    expect_pkt(32'h700, 32'h704, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 3'b101, 32'h700, 32'h704, 32'hFFFF_FFFF, 1, 32'h10, 0);
    // BGEU: 0xFFFFFFFF >= 1 true
    expect_pkt(32'h700, 32'h710, 1, 0, 1, 0);
    step(1, 0, 1, 0, 0, 3'b111, 32'h700, 32'h710, 32'hFFFF_FFFF, 1, 32'h10, 0);
    // Target wraps mod 2^32
    expect_pkt(32'hFFFF_FFF0, 32'h10, 1, 0, 1, 0);
    step(1, 0, 1, 0, 0, 3'b000, 32'hFFFF_FFF0, 32'h10, 3, 3, 32'h20, 0);
    // Accepted non-control: no pulse, not counted
    nop(0, 0);
    chk_cnt(10, 3);

    // Reset in the middle of a squash window
    expect_pkt(32'h800, 32'h840, 1, 0, 1, 1);
    step(1, 0, 1, 0, 0, 3'b000, 32'h800, 32'h804, 9, 9, 32'h40, 0);
    chk_cnt(11, 4);
    rst_n = 1'b0;
    nop(0, 1);
    rst_n = 1'b1;
    chk_zero("midsq_reset");
    chk("post_reset_sq", {31'd0, a_sq}, 32'd0);
    expect_pkt(32'h900, 32'h910, 1, 0, 1, 1);
    step(1, 0, 1, 0, 0, 3'b001, 32'h900, 32'h904, 1, 2, 32'h10, 0);
    chk_cnt(1, 1);
    idle(0);
    idle(0);

    // 16 mispredicts: the 4-bit instance must saturate, not wrap
    for (int i = 0; i < 16; i++) begin
      expect_pkt(32'h1000, 32'h1008, 1, 0, 1, 1);
      step(1, 0, 1, 0, 0, 3'b001, 32'h1000, 32'h1004, 1, 2, 32'h8, 0);
      idle(0);
      idle(0);
    end
    chk_cnt(17, 17);
    chk("sat_cnt_mispred", {28'd0, b_cm}, 32'hF);
    chk("sat_cnt_ctrl", {28'd0, b_cc}, 32'hF);

    idle(0);
    idle(0);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/br_resolve_agex.md
Name: br_resolve_agex

Overview:
- Branch-resolution unit in the AGEX stage; the producer end of the AGEX-to-FE feedback bundle that the fetch stage's BTB/PHT/BHR predictor consumes.
- Per accepted control-flow instruction: evaluates the branch condition, computes the actual next PC, and compares it with the next PC predicted at fetch.
- Emits a registered one-cycle resolution/redirect packet to FE.
- Squashes wrong-path instructions for a fixed window after each redirect and keeps saturating branch/mispredict statistics.

Parameters:
- DBITS, 32, data/PC width.
- INSTSIZE, 4, PC increment.
- SQUASH_CYCLES, 2, accepted slots squashed after a redirect (1..7).
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (block resets when reset==0)
- in_valid  in  1  AGEX latch holds a valid instruction
- in_stall  in  1  AGEX held by downstream; no acceptance this cycle
- in_pc  in  DBITS  instruction PC
- in_pred_npc  in  DBITS  next PC chosen by FE (carried down the latches)
- in_is_br  in  1  conditional branch
- in_is_jal  in  1  JAL
- in_is_jalr  in  1  JALR
- in_funct3  in  3  branch type
- in_rs1  in  DBITS  operand 1
- in_rs2  in  DBITS  operand 2
- in_imm  in  DBITS  sign-extended immediate
- fe_mispred  out  1  redirect FE this cycle
- fe_target  out  DBITS  actual next PC
- fe_pc  out  DBITS  resolved instruction PC
- fe_is_br  out  1  resolved conditional branch
- fe_is_jmp  out  1  resolved JAL/JALR
- fe_br_cond  out  1  actual taken (1 for jumps)
- squash_out  out  1  current AGEX instruction is wrong-path; downstream must drop it
- cnt_ctrl  out  CNT_W  resolved control instructions
- cnt_mispred  out  CNT_W  redirects issued

Behaviour:
- accept = in_valid & ~in_stall & ~squashing. Only accepted instructions are resolved; a stalled instruction is resolved exactly once, on the cycle the stall drops.
- Condition by funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 evaluate to not-taken.
- Target:
  - branch/JAL: in_pc+in_imm.
  - JALR: (in_rs1+in_imm) with bit0 cleared.
  - All sums mod 2^DBITS.
- actual_npc = taken ? target : in_pc+INSTSIZE, where taken = cond for branches and 1 for jumps. Non-control instructions: actual_npc = in_pc+INSTSIZE, never mispredict, never counted.
- mispred = accept & (is_br|is_jal|is_jalr) & (actual_npc != in_pred_npc).
- Output register (latency 1):
  - On the edge accepting a control instruction, fe_pc, fe_target=actual_npc, fe_is_br, fe_is_jmp, fe_br_cond and fe_mispred load. They are valid for exactly the following cycle.
  - Next cycle they return to 0 unless another accept occurs.
  - fe_target is driven even when not mispredicted, so FE can update its BTB.
- If in_is_br and in_is_jal/in_is_jalr are asserted together: jump wins, fe_is_br=0.
- States:
  - RUN: normal operation.
  - SQUASH: 3-bit counter sq_cnt.
  - RUN→SQUASH on the edge issuing a mispredict; sq_cnt=SQUASH_CYCLES.
  - In SQUASH, squash_out=in_valid. Each cycle with in_stall=0 decrements sq_cnt; stalled cycles do not count.
  - SQUASH→RUN when sq_cnt reaches 0 on a decrement.
  - Mispredicts are impossible in SQUASH since nothing is accepted there.
- Counters:
  - cnt_ctrl increments per accepted control instruction.
  - cnt_mispred increments per mispredict.
  - Both saturate at all-ones; no wrap.
- Reset (reset==0 at an edge) clears all outputs, both counters, sq_cnt, and state→RUN, including mid-squash and over any pending output pulse.

Test Plan:
- BEQ, pc=0x100, imm=0x20, rs1=rs2=5, pred_npc=0x120 → next cycle fe_br_cond=1, fe_target=0x120, fe_mispred=0; cnt_ctrl=1, cnt_mispred=0.
- BLT signed, rs1=0xFFFFFFFF, rs2=1, pc=0x200, imm=0x40, pred_npc=0x204 → fe_mispred=1, fe_target=0x240. Following two unstalled valid inputs give squash_out=1 and no fe_* pulse; the third is resolved normally.
- BLTU with same operands, pred_npc=0x204 → not taken, fe_target=0x204, fe_mispred=0.
- JALR, rs1=0x1003, imm=0x10, pred_npc=0x0 → fe_target=0x1012 (bit0 cleared), fe_is_jmp=1, fe_br_cond=1, fe_mispred=1.
- Branch held with in_stall=1 for 3 cycles, then released → exactly one fe_* pulse and cnt_ctrl +1. Repeat with a stall during SQUASH → window extends by the stalled cycles.
- Counters preloaded near saturation via CNT_W=4 build: 16 mispredicts → cnt_mispred stays 0xF. Assert reset=0 during SQUASH → next cycle all outputs 0 and state RUN, and the next mispredicting branch is accepted.
